// File: rtl/k2_program_loader.sv
// K2 program memory loader: byte-stream image load into instruction memory,
// holds the processor in reset until a complete image is present.
module k2_program_loader #(
    parameter int IW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    input  logic [IW-1:0] load_byte,
    output logic          load_ready,
    input  logic          reload,
    input  logic [AW-1:0] ProgramAddress,
    output logic [IW-1:0] instruction_data,
    output logic          cpu_rst_n,
    output logic          len_err
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        WAIT_LEN,
        LOAD,
        RUN,
        CLEAR
    } state_t;

    state_t        state, state_n;
    logic [AW:0]   cnt, cnt_n;
    logic [AW:0]   len, len_n;
    logic          err_n;
    logic          we;
    logic [IW-1:0] wdata;
    logic          hs;
    logic          len_ok;
    logic [IW-1:0] mem [DEPTH];

    assign load_ready       = (state == WAIT_LEN) || (state == LOAD);
    assign hs               = load_valid && load_ready;
    assign len_ok           = (load_byte != '0) && (load_byte <= IW'(DEPTH));
    assign instruction_data = mem[ProgramAddress];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = len;
        err_n   = len_err;
        we      = 1'b0;
        wdata   = load_byte;
        // reload wins over any handshake in the same cycle
        if (reload) begin
            state_n = CLEAR;
            cnt_n   = '0;
        end else begin
            unique case (state)
                WAIT_LEN: begin
                    if (hs) begin
                        if (len_ok) begin
                            len_n   = load_byte[AW:0];
                            cnt_n   = '0;
                            err_n   = 1'b0;
                            state_n = LOAD;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (hs) begin
                        we    = 1'b1;
                        cnt_n = cnt + 1'b1;
                        if (cnt == len - 1'b1) state_n = RUN;
                    end
                end
                RUN: begin
                end
                CLEAR: begin
                    we    = 1'b1;
                    wdata = '0;
                    cnt_n = cnt + 1'b1;
                    if (cnt == (AW+1)'(DEPTH - 1)) state_n = WAIT_LEN;
                end
                default: begin
                    state_n = WAIT_LEN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_LEN;
            cnt       <= '0;
            len       <= '0;
            len_err   <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            len       <= len_n;
            len_err   <= err_n;
            cpu_rst_n <= (state_n == RUN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[cnt[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: tb/tb_k2_program_loader.sv
// Scoreboard bench for k2_program_loader: expected images are queued as
// stimulus is driven and compared against full memory read-back.
module tb_k2_program_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_byte = '0;
    logic       load_ready;
    logic       reload = 1'b0;
    logic [3:0] ProgramAddress = '0;
    logic [7:0] instruction_data;
    logic       cpu_rst_n;
    logic       len_err;

    int total = 0;
    int bad = 0;
    logic [7:0] img [16];
    logic [7:0] exp_q [$];

    k2_program_loader #(.IW(8), .AW(4)) dut (
        .clk(clk),
        .rst(rst),
        .load_valid(load_valid),
        .load_byte(load_byte),
        .load_ready(load_ready),
        .reload(reload),
        .ProgramAddress(ProgramAddress),
        .instruction_data(instruction_data),
        .cpu_rst_n(cpu_rst_n),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic img_clear();
        for (int i = 0; i < 16; i++) img[i] = '0;
    endtask

    task automatic push_img();
        for (int i = 0; i < 16; i++) exp_q.push_back(img[i]);
    endtask

    task automatic dump(input string tag);
        logic [7:0] e;
        for (int a = 0; a < 16; a++) begin
            ProgramAddress = 4'(a);
            #1;
            if (exp_q.size() == 0) begin
                chk({tag, "_q_empty"}, 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("%s_m%0d", tag, a), instruction_data, e);
            end
        end
    endtask

    task automatic put(input logic [7:0] b);
        int t;
        t = 0;
        load_valid = 1'b1;
        load_byte  = b;
        while (!load_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reload();
        int t;
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        t = 0;
        while (!load_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) chk("reload_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        // reset values
        #2;
        chk("rst_ready", load_ready, 1);
        chk("rst_cpu", cpu_rst_n, 0);
        chk("rst_err", len_err, 0);
        img_clear();
        push_img();
        dump("rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // length 3: A1 B2 C3
        img_clear();
        img[0] = 8'hA1; img[1] = 8'hB2; img[2] = 8'hC3;
        push_img();
        put(8'd3);
        put(8'hA1);
        put(8'hB2);
        chk("t1_cpu_pre", cpu_rst_n, 0);
        put(8'hC3);
        chk("t1_cpu_post", cpu_rst_n, 1);
        chk("t1_ready", load_ready, 0);
        idle();
        dump("t1");

        // reload from RUN
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        chk("rl_cpu", cpu_rst_n, 0);
        chk("rl_ready0", load_ready, 0);
        repeat (15) @(posedge clk);
        #1;
        chk("rl_ready15", load_ready, 0);
        @(posedge clk);
        #1;
        chk("rl_ready16", load_ready, 1);
        img_clear();
        push_img();
        dump("rl");
        img[0] = 8'h7E;
        push_img();
        put(8'd1);
        put(8'h7E);
        chk("rl_cpu_run", cpu_rst_n, 1);
        idle();
        dump("rl7e");

        // full-depth image
        do_reload();
        img_clear();
        for (int i = 0; i < 16; i++) img[i] = 8'(i);
        push_img();
        put(8'd16);
        for (int i = 0; i < 15; i++) put(8'(i));
        chk("l16_cpu_pre", cpu_rst_n, 0);
        chk("l16_ready_pre", load_ready, 1);
        put(8'h0F);
        chk("l16_cpu_post", cpu_rst_n, 1);
        chk("l16_ready_post", load_ready, 0);
        idle();
        dump("l16");

        // illegal lengths
        do_reload();
        put(8'h00);
        chk("le0_err", len_err, 1);
        chk("le0_ready", load_ready, 1);
        put(8'h11);
        chk("le11_err", len_err, 1);
        chk("le11_ready", load_ready, 1);
        img_clear();
        img[0] = 8'hAA; img[1] = 8'hBB;
        push_img();
        put(8'd2);
        chk("le2_err", len_err, 0);
        put(8'hAA);
        chk("le2_cpu_pre", cpu_rst_n, 0);
        put(8'hBB);
        chk("le2_cpu_post", cpu_rst_n, 1);
        idle();
        dump("le");

        // reload collides with second program byte
        do_reload();
        put(8'd4);
        put(8'h55);
        @(negedge clk);
        load_valid = 1'b1;
        load_byte  = 8'h66;
        reload     = 1'b1;
        @(posedge clk);
        #1;
        reload     = 1'b0;
        load_valid = 1'b0;
        chk("col_ready", load_ready, 0);
        chk("col_cpu", cpu_rst_n, 0);
        repeat (16) @(posedge clk);
        #1;
        chk("col_ready16", load_ready, 1);
        img_clear();
        push_img();
        dump("col");

        // asynchronous reset mid-load
        ProgramAddress = 4'd0;
        put(8'd3);
        put(8'h12);
        load_valid = 1'b0;
        #1;
        chk("ar_pre", instruction_data, 8'h12);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_data", instruction_data, 0);
        chk("ar_ready", load_ready, 1);
        chk("ar_cpu", cpu_rst_n, 0);
        chk("ar_err", len_err, 0);
        @(negedge clk);
        rst = 1'b0;
        img_clear();
        push_img();
        dump("ar");
        img[0] = 8'h9C;
        push_img();
        @(negedge clk);
        put(8'd1);
        put(8'h9C);
        chk("ar_cpu_run", cpu_rst_n, 1);
        idle();
        dump("ar9c");

        chk("q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
